// File: rtl/smallcalc_datapath_if.sv
// Control-word / result bundle between the small-calculator control unit (master)
// and its datapath (slave).
interface smallcalc_datapath_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [1:0]   s1;
  logic         we;
  logic [1:0]   wa;
  logic         rea;
  logic [1:0]   raa;
  logic         reb;
  logic [1:0]   rab;
  logic [1:0]   c;
  logic         s2;
  logic         doneF;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;
  logic         done;

  modport master (
    output in1, in2, s1, we, wa, rea, raa, reb, rab, c, s2, doneF,
    input  out, carry, zero, done
  );

  modport slave (
    input  in1, in2, s1, we, wa, rea, raa, reb, rab, c, s2, doneF,
    output out, carry, zero, done
  );
endinterface

// File: rtl/smallcalc_datapath.sv
// Small-calculator datapath: 4-entry register file, 2-operand ALU and registered
// result/flags/done outputs.
module smallcalc_datapath #(
  parameter int unsigned W = 4
) (
  input logic                 clk,
  input logic                 rst,
  smallcalc_datapath_if.slave bus
);

  logic [3:0][W-1:0] rf_q, rf_d;
  logic [W-1:0]      out_q, out_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;

  logic [W-1:0] op_a, op_b, res, wdata;
  logic [W:0]   alu_full;
  logic         alu_carry;

  // Operands and ALU; SUB borrow falls out of bit W of the widened difference.
  always_comb begin
    op_a     = bus.rea ? rf_q[bus.raa] : '0;
    op_b     = bus.reb ? rf_q[bus.rab] : '0;
    alu_full = '0;
    case (bus.c)
      2'b00:   alu_full = {1'b0, op_a} + {1'b0, op_b};
      2'b01:   alu_full = {1'b0, op_a} - {1'b0, op_b};
      2'b10:   alu_full = {1'b0, op_a & op_b};
      default: alu_full = {1'b0, op_a ^ op_b};
    endcase
    res       = alu_full[W-1:0];
    alu_carry = alu_full[W];
  end

  always_comb begin
    wdata = '0;
    case (bus.s1)
      2'b00:   wdata = bus.in1;
      2'b01:   wdata = bus.in2;
      2'b10:   wdata = '0;
      default: wdata = res;
    endcase
  end

  // Writes land at the edge, so a same-cycle read still sees the old entry.
  always_comb begin
    rf_d = rf_q;
    if (bus.we) begin
      rf_d[bus.wa] = wdata;
    end
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (bus.s2) begin
      out_d   = res;
      carry_d = alu_carry;
      zero_d  = (res == '0);
    end
    done_d = bus.doneF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q    <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rf_q    <= rf_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_smallcalc_datapath.sv
// Bench for smallcalc_datapath: directed control sequences plus random control words,
// all checked against an arithmetic model of the register file and ALU.
module tb_smallcalc_datapath;
  localparam int unsigned W = 4;
  localparam int          Mask = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smallcalc_datapath_if #(.W(W)) bus ();

  smallcalc_datapath #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_r[4];
  int m_out, m_cy, m_z, m_done;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void alu(input int a, input int b, input int op,
                              output int res, output int cy);
    case (op)
      0: begin res = (a + b) & Mask; cy = ((a + b) > Mask) ? 1 : 0; end
      1: begin res = (a - b) & Mask; cy = (a < b) ? 1 : 0; end
      2: begin res = a & b;          cy = 0; end
      default: begin res = a ^ b;    cy = 0; end
    endcase
  endfunction

  task automatic set_ctl(input int we, input int wa, input int s1, input int rea,
                         input int raa, input int reb, input int rab, input int c,
                         input int s2, input int dn);
    bus.we    = 1'(we);
    bus.wa    = 2'(wa);
    bus.s1    = 2'(s1);
    bus.rea   = 1'(rea);
    bus.raa   = 2'(raa);
    bus.reb   = 1'(reb);
    bus.rab   = 2'(rab);
    bus.c     = 2'(c);
    bus.s2    = 1'(s2);
    bus.doneF = 1'(dn);
  endtask

  // One clock: predict from pre-edge model state, then compare all outputs.
  task automatic cycle(input string tag);
    int a, b, res, cy, wd;
    a = bus.rea ? m_r[bus.raa] : 0;
    b = bus.reb ? m_r[bus.rab] : 0;
    alu(a, b, int'(bus.c), res, cy);
    case (bus.s1)
      2'd0:    wd = int'(bus.in1);
      2'd1:    wd = int'(bus.in2);
      2'd2:    wd = 0;
      default: wd = res;
    endcase
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_out = 0; m_cy = 0; m_z = 0; m_done = 0;
    end else begin
      if (bus.we) m_r[bus.wa] = wd;
      if (bus.s2) begin
        m_out = res;
        m_cy  = cy;
        m_z   = (res == 0) ? 1 : 0;
      end
      m_done = int'(bus.doneF);
    end
    check({tag, ".out"},   int'(bus.out),   m_out);
    check({tag, ".carry"}, int'(bus.carry), m_cy);
    check({tag, ".zero"},  int'(bus.zero),  m_z);
    check({tag, ".done"},  int'(bus.done),  m_done);
  endtask

  task automatic idle(input string tag);
    set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(tag);
  endtask

  task automatic load(input int x, input int y);
    bus.in1 = W'(x);
    set_ctl(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("ld1");
    bus.in2 = W'(y);
    set_ctl(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle("ld2");
  endtask

  // Load R1/R2, then op with s2=1 so the arithmetic carry reaches the outputs.
  task automatic op_pair(input string tag, input int x, input int y, input int op,
                         input int e_out, input int e_cy, input int e_z);
    load(x, y);
    set_ctl(1, 3, 3, 1, 1, 1, 2, op, 1, 0);
    cycle(tag);
    check({tag, ".k_out"},   int'(bus.out),   e_out);
    check({tag, ".k_carry"}, int'(bus.carry), e_cy);
    check({tag, ".k_zero"},  int'(bus.zero),  e_z);
  endtask

  // Standard IDLE, LD1, LD2, WAIT, OP, DONE sequence.
  task automatic std_seq(input int x, input int y, input int op);
    idle("idle");
    load(x, y);
    idle("wait");
    set_ctl(1, 3, 3, 1, 1, 1, 2, op, 0, 0);
    cycle("op");
    set_ctl(0, 0, 0, 1, 3, 1, 3, 2, 1, 1);
    cycle("done");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_out = 0; m_cy = 0; m_z = 0; m_done = 0;
    bus.in1 = '0;
    bus.in2 = '0;
    set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle("rst0");
    cycle("rst1");
    check("rst.k_out",  int'(bus.out),  0);
    check("rst.k_done", int'(bus.done), 0);
    rst = 1'b0;

    // 1: 5 + 3 through the full sequence.
    std_seq(5, 3, 0);
    check("t1.k_out",  int'(bus.out),  8);
    check("t1.k_zero", int'(bus.zero), 0);
    check("t1.k_done", int'(bus.done), 1);
    idle("t1.after");
    check("t1.k_done_low", int'(bus.done), 0);

    // 2-4: arithmetic and logic corners.
    op_pair("sub35", 3, 5, 1, 14, 1, 0);
    op_pair("sub53", 5, 3, 1, 2, 0, 0);
    op_pair("add88", 8, 8, 0, 0, 1, 1);
    op_pair("add98", 9, 8, 0, 1, 1, 0);
    op_pair("andca", 12, 10, 2, 8, 0, 0);
    op_pair("xorca", 12, 10, 3, 6, 0, 0);
    op_pair("and5a", 5, 10, 2, 0, 0, 1);

    // 5: read-during-write returns old entry; rea=0 forces A to zero.
    load(5, 0);
    bus.in1 = W'(7);
    set_ctl(1, 1, 0, 1, 1, 1, 1, 2, 1, 0);
    cycle("rdw0");
    check("rdw0.k_out", int'(bus.out), 5);
    set_ctl(0, 1, 0, 1, 1, 1, 1, 2, 1, 0);
    cycle("rdw1");
    check("rdw1.k_out", int'(bus.out), 7);
    set_ctl(0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    cycle("rea0");
    check("rea0.k_out", int'(bus.out), 7);

    // 6: reset in the op cycle beats we and s2, then a clean sequence.
    load(2, 3);
    set_ctl(1, 3, 3, 1, 1, 1, 2, 0, 1, 1);
    rst = 1'b1;
    cycle("rstop");
    rst = 1'b0;
    check("rstop.k_out", int'(bus.out), 0);
    set_ctl(0, 0, 0, 1, 3, 1, 1, 0, 1, 0);
    cycle("rstop.r3r1");
    check("rstop.k_cleared", int'(bus.out), 0);
    std_seq(2, 3, 0);
    check("t6.k_out", int'(bus.out), 5);

    // Random control words, occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 24) == 0);
      bus.in1 = W'($urandom);
      bus.in2 = W'($urandom);
      set_ctl($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1));
      cycle("rnd");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
